// File: rtl/u110_pci_monitor_if.sv
// 68040-side PCI cycle tracking signals: the master drives the bus/target inputs,
// the monitor (slave) returns the termination pulses, busy state and sticky flags.
interface u110_pci_monitor_if;
    logic       TSn;
    logic       PCI_CYCLEn;
    logic [1:0] SIZ;
    logic       DEVSELn;
    logic       TRDYn;
    logic       STOPn;
    logic       FLAG_CLR;
    logic       PCI_TACK;
    logic       PCI_TEA;
    logic       BUSY;
    logic       MABORT;
    logic       TABORT;

    modport master (
        output TSn, PCI_CYCLEn, SIZ, DEVSELn, TRDYn, STOPn, FLAG_CLR,
        input  PCI_TACK, PCI_TEA, BUSY, MABORT, TABORT
    );

    modport slave (
        input  TSn, PCI_CYCLEn, SIZ, DEVSELn, TRDYn, STOPn, FLAG_CLR,
        output PCI_TACK, PCI_TEA, BUSY, MABORT, TABORT
    );
endinterface

// File: rtl/u110_pci_monitor.sv
// Tracks one 68040 cycle into PCI space and generates TACK/TEA terminations.
// Pulses are registered: a target response sampled at edge N is reported from edge N to N+1.
module u110_pci_monitor #(
    parameter int DEVSEL_TO = 6,
    parameter int TRDY_TO   = 16
) (
    input  logic                  CLK40,
    input  logic                  RESET,
    u110_pci_monitor_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, WAIT_DEV, DATA, DONE} state_t;

    localparam logic [4:0] DEV_LIM  = 5'(DEVSEL_TO - 1);
    localparam logic [4:0] TRDY_LIM = 5'(TRDY_TO - 1);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [2:0] beats_q, beats_d;
    logic       disc_q, disc_d;
    logic       tack_q, tack_d;
    logic       tea_q, tea_d;
    logic       mabort_q, mabort_d;
    logic       tabort_q, tabort_d;
    logic       set_mabort, set_tabort;
    logic [4:0] cnt_inc;

    assign cnt_inc = (cnt_q == 5'h1f) ? cnt_q : cnt_q + 5'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beats_d    = beats_q;
        disc_d     = 1'b0;
        tack_d     = 1'b0;
        tea_d      = 1'b0;
        set_mabort = 1'b0;
        set_tabort = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.TSn && !bus.PCI_CYCLEn) begin
                    state_d = WAIT_DEV;
                    cnt_d   = 5'd0;
                    beats_d = (bus.SIZ == 2'b11) ? 3'd4 : 3'd1;
                end
            end
            WAIT_DEV: begin
                if (!bus.DEVSELn) begin
                    state_d = DATA;
                    cnt_d   = 5'd0;
                end else if (cnt_q >= DEV_LIM) begin
                    tea_d      = 1'b1;
                    set_mabort = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DATA: begin
                // A disconnect-with-data spends one extra clock here to emit its TEA.
                if (disc_q) begin
                    tea_d   = 1'b1;
                    state_d = DONE;
                end else if (!bus.TRDYn) begin
                    tack_d  = 1'b1;
                    cnt_d   = 5'd0;
                    beats_d = (beats_q == 3'd0) ? 3'd0 : beats_q - 3'd1;
                    if (beats_q <= 3'd1) begin
                        state_d = DONE;
                    end else if (!bus.STOPn) begin
                        disc_d = 1'b1;
                    end
                end else if (!bus.STOPn) begin
                    tea_d      = 1'b1;
                    set_tabort = bus.DEVSELn;
                    state_d    = DONE;
                end else if (cnt_q >= TRDY_LIM) begin
                    tea_d      = 1'b1;
                    set_tabort = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mabort_d = set_mabort ? 1'b1 : (bus.FLAG_CLR ? 1'b0 : mabort_q);
        tabort_d = set_tabort ? 1'b1 : (bus.FLAG_CLR ? 1'b0 : tabort_q);
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            beats_q  <= 3'd0;
            disc_q   <= 1'b0;
            tack_q   <= 1'b0;
            tea_q    <= 1'b0;
            mabort_q <= 1'b0;
            tabort_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beats_q  <= beats_d;
            disc_q   <= disc_d;
            tack_q   <= tack_d;
            tea_q    <= tea_d;
            mabort_q <= mabort_d;
            tabort_q <= tabort_d;
        end
    end

    assign bus.PCI_TACK = tack_q;
    assign bus.PCI_TEA  = tea_q;
    assign bus.BUSY     = (state_q == WAIT_DEV) || (state_q == DATA);
    assign bus.MABORT   = mabort_q;
    assign bus.TABORT   = tabort_q;

endmodule

// File: tb/tb_u110_pci_monitor.sv
// Directed bench for u110_pci_monitor: a cycle-level reference model checked every clock,
// plus literal expectations for latencies, pulse counts and flag behaviour.
module tb_u110_pci_monitor;

    localparam int DEV_TO  = 6;
    localparam int TRDY_TO = 16;

    logic CLK40;
    logic RESET;
    u110_pci_monitor_if bus();

    u110_pci_monitor #(.DEVSEL_TO(DEV_TO), .TRDY_TO(TRDY_TO)) dut (
        .CLK40 (CLK40),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK40 = 1'b0;
    always #5 CLK40 = ~CLK40;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: transaction phase as separate flags, timeouts as elapsed-clock counts.
    bit m_addr, m_data, m_tail, m_disc;
    int m_waited, m_beats;
    bit m_tack, m_tea, m_mab, m_tab;

    task automatic model_step();
        bit set_m, set_t, finish;
        set_m = 0; set_t = 0; finish = 0;
        m_tack = 0; m_tea = 0;
        if (RESET) begin
            m_addr = 0; m_data = 0; m_tail = 0; m_disc = 0;
            m_waited = 0; m_beats = 0; m_mab = 0; m_tab = 0;
            return;
        end
        if (m_tail) begin
            m_tail = 0;
        end else if (m_addr) begin
            if (!bus.DEVSELn) begin
                m_addr = 0; m_data = 1; m_waited = 0;
            end else begin
                m_waited++;
                if (m_waited == DEV_TO) begin
                    m_tea = 1; set_m = 1; finish = 1;
                end
            end
        end else if (m_data) begin
            if (m_disc) begin
                m_tea = 1; m_disc = 0; finish = 1;
            end else if (!bus.TRDYn) begin
                m_tack = 1; m_waited = 0; m_beats--;
                if (m_beats == 0) finish = 1;
                else if (!bus.STOPn) m_disc = 1;
            end else if (!bus.STOPn) begin
                m_tea = 1; set_t = bus.DEVSELn; finish = 1;
            end else begin
                m_waited++;
                if (m_waited == TRDY_TO) begin
                    m_tea = 1; set_t = 1; finish = 1;
                end
            end
        end else if (!bus.TSn && !bus.PCI_CYCLEn) begin
            m_addr = 1; m_waited = 0;
            m_beats = (bus.SIZ == 2'b11) ? 4 : 1;
        end
        if (finish) begin
            m_addr = 0; m_data = 0; m_tail = 1;
        end
        m_mab = set_m ? 1'b1 : (bus.FLAG_CLR ? 1'b0 : m_mab);
        m_tab = set_t ? 1'b1 : (bus.FLAG_CLR ? 1'b0 : m_tab);
    endtask

    initial forever begin
        @(posedge CLK40);
        model_step();
    end

    initial forever begin
        @(negedge CLK40);
        if (chk_en) begin
            chk("tack",   int'(bus.PCI_TACK), int'(m_tack));
            chk("tea",    int'(bus.PCI_TEA),  int'(m_tea));
            chk("busy",   int'(bus.BUSY),     int'(m_addr | m_data));
            chk("mabort", int'(bus.MABORT),   int'(m_mab));
            chk("tabort", int'(bus.TABORT),   int'(m_tab));
            chk("tack_tea_excl", int'(bus.PCI_TACK & bus.PCI_TEA), 0);
        end
    end

    task automatic step();
        @(posedge CLK40);
        #1;
    endtask

    task automatic start_cycle(input logic [1:0] siz);
        bus.TSn = 1'b0; bus.PCI_CYCLEn = 1'b0; bus.SIZ = siz;
        step();
        bus.TSn = 1'b1; bus.PCI_CYCLEn = 1'b1; bus.SIZ = 2'b00;
    endtask

    int n, lat;

    initial begin
        RESET = 1'b1;
        bus.TSn = 1'b1; bus.PCI_CYCLEn = 1'b1; bus.SIZ = 2'b00;
        bus.DEVSELn = 1'b1; bus.TRDYn = 1'b1; bus.STOPn = 1'b1; bus.FLAG_CLR = 1'b0;
        step(); step();
        chk("rst_tack",   int'(bus.PCI_TACK), 0);
        chk("rst_tea",    int'(bus.PCI_TEA),  0);
        chk("rst_busy",   int'(bus.BUSY),     0);
        chk("rst_mabort", int'(bus.MABORT),   0);
        chk("rst_tabort", int'(bus.TABORT),   0);
        chk_en = 1'b1;
        RESET = 1'b0;
        step();

        // TSn outside PCI space is ignored
        bus.TSn = 1'b0; bus.PCI_CYCLEn = 1'b1;
        step();
        chk("ts_nonpci_busy", int'(bus.BUSY), 0);
        bus.TSn = 1'b1;

        // Single read; TSn during DONE is ignored
        start_cycle(2'b00);
        chk("single_busy", int'(bus.BUSY), 1);
        bus.DEVSELn = 1'b0; step();
        chk("single_no_early_tack", int'(bus.PCI_TACK), 0);
        bus.TRDYn = 1'b0; step();
        chk("single_tack", int'(bus.PCI_TACK), 1);
        chk("single_busy_done", int'(bus.BUSY), 0);
        bus.TRDYn = 1'b1; bus.DEVSELn = 1'b1;
        bus.TSn = 1'b0; bus.PCI_CYCLEn = 1'b0;
        step();
        chk("ts_in_done_ignored", int'(bus.BUSY), 0);
        bus.TSn = 1'b1; bus.PCI_CYCLEn = 1'b1;
        step();
        chk("single_idle", int'(bus.BUSY), 0);

        // Burst of four beats
        start_cycle(2'b11);
        bus.DEVSELn = 1'b0; step();
        bus.TRDYn = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.PCI_TACK) n++;
            if (i == 2) chk("burst_busy_mid", int'(bus.BUSY), 1);
        end
        chk("burst_tack_count", n, 4);
        chk("burst_done_busy", int'(bus.BUSY), 0);
        bus.TRDYn = 1'b1; bus.DEVSELn = 1'b1;
        step();
        chk("burst_no_extra_tack", int'(bus.PCI_TACK), 0);

        // Master abort
        start_cycle(2'b00);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.PCI_TEA && lat == 0) lat = k;
        end
        chk("mabort_latency", lat, 6);
        chk("mabort_set", int'(bus.MABORT), 1);
        bus.FLAG_CLR = 1'b1; step(); bus.FLAG_CLR = 1'b0;
        chk("mabort_cleared", int'(bus.MABORT), 0);

        // Master abort while FLAG_CLR held: set wins, then clear takes effect
        bus.FLAG_CLR = 1'b1;
        start_cycle(2'b00);
        for (int k = 1; k <= 6; k++) step();
        chk("setclr_tea", int'(bus.PCI_TEA), 1);
        chk("setclr_set_wins", int'(bus.MABORT), 1);
        step();
        chk("setclr_cleared", int'(bus.MABORT), 0);
        bus.FLAG_CLR = 1'b0;

        // Disconnect with data on beat 2
        start_cycle(2'b11);
        bus.DEVSELn = 1'b0; step();
        bus.TRDYn = 1'b0; step();
        chk("disc_tack1", int'(bus.PCI_TACK), 1);
        bus.STOPn = 1'b0; step();
        chk("disc_tack2", int'(bus.PCI_TACK), 1);
        chk("disc_no_tea_yet", int'(bus.PCI_TEA), 0);
        bus.TRDYn = 1'b1; bus.STOPn = 1'b1; step();
        chk("disc_tea", int'(bus.PCI_TEA), 1);
        chk("disc_tabort", int'(bus.TABORT), 0);
        bus.DEVSELn = 1'b1; step();
        chk("disc_idle", int'(bus.BUSY), 0);

        // Target timeout
        start_cycle(2'b00);
        bus.DEVSELn = 1'b0; step();
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.PCI_TEA && lat == 0) lat = k;
        end
        chk("ttimeout_latency", lat, 16);
        chk("ttimeout_tabort", int'(bus.TABORT), 1);
        bus.DEVSELn = 1'b1;
        bus.FLAG_CLR = 1'b1; step(); bus.FLAG_CLR = 1'b0;
        chk("tabort_cleared", int'(bus.TABORT), 0);

        // STOPn without TRDYn: target abort only when DEVSELn is high
        start_cycle(2'b00);
        bus.DEVSELn = 1'b0; step();
        bus.DEVSELn = 1'b1; bus.STOPn = 1'b0; step();
        chk("tabort_stop_tea", int'(bus.PCI_TEA), 1);
        chk("tabort_stop_flag", int'(bus.TABORT), 1);
        bus.STOPn = 1'b1; step();
        bus.FLAG_CLR = 1'b1; step(); bus.FLAG_CLR = 1'b0;
        start_cycle(2'b00);
        bus.DEVSELn = 1'b0; step();
        bus.STOPn = 1'b0; step();
        chk("retry_tea", int'(bus.PCI_TEA), 1);
        chk("retry_no_tabort", int'(bus.TABORT), 0);
        bus.STOPn = 1'b1; bus.DEVSELn = 1'b1; step();

        // Reset mid-burst after two beats, with MABORT set beforehand
        start_cycle(2'b00);
        for (int k = 1; k <= 7; k++) step();
        chk("pre_reset_mabort", int'(bus.MABORT), 1);
        start_cycle(2'b11);
        bus.DEVSELn = 1'b0; step();
        bus.TRDYn = 1'b0; step(); step();
        RESET = 1'b1; step();
        chk("midrst_tack", int'(bus.PCI_TACK), 0);
        chk("midrst_tea",  int'(bus.PCI_TEA),  0);
        chk("midrst_busy", int'(bus.BUSY),     0);
        chk("midrst_mabort", int'(bus.MABORT), 0);
        RESET = 1'b0; bus.TRDYn = 1'b1; bus.DEVSELn = 1'b1;
        start_cycle(2'b00);
        chk("postrst_no_tack", int'(bus.PCI_TACK), 0);
        chk("postrst_no_tea",  int'(bus.PCI_TEA),  0);
        chk("postrst_ts_accepted", int'(bus.BUSY), 1);
        bus.DEVSELn = 1'b0; step();
        bus.TRDYn = 1'b0; step();
        chk("postrst_tack", int'(bus.PCI_TACK), 1);
        bus.TRDYn = 1'b1; bus.DEVSELn = 1'b1;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
